// File: rtl/des_arb_pkg.sv
// Shared types and source identifiers for the deserializer ingress arbiter.
package des_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        HOLDOFF = 2'd3
    } arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/des_ingress_arbiter_rr_pick2.sv
// Two-way round-robin choice: the source that was not granted last wins a tie.
module rr_pick2
    import des_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = SRC_A;
        if (req_a && req_b) begin
            winner = (last_grant == SRC_A) ? SRC_B : SRC_A;
        end else if (req_b) begin
            winner = SRC_B;
        end
    end

endmodule

// File: rtl/des_ingress_arbiter.sv
// Sole writer of the byte queue: grants sources A/B round-robin, enqueues the
// byte, acks the source, then holds off one cycle while the source drops ready.
//
// state   | meaning
// IDLE    | waiting for a ready source and a non-full queue
// CAPTURE | enqueue strobe high with the latched byte
// ACK     | ack pulse to the granted source
// HOLDOFF | data_ready ignored while the source deasserts it
module des_ingress_arbiter
    import des_arb_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STALL_MAX = 16
) (
    input  logic             clock_100KHZ,
    input  logic             reset,
    input  logic             data_ready_a,
    input  logic [7:0]       data_a,
    output logic             ack_a,
    input  logic             data_ready_b,
    input  logic [7:0]       data_b,
    output logic             ack_b,
    input  logic             queue_full,
    output logic             enqueue_out,
    output logic [7:0]       data_to_queue,
    output logic             grant_src,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             stall_err,
    output logic [1:0]       state_out
);

    localparam logic [7:0] STALL_LIM = STALL_MAX[7:0];

    arb_state_t       state_q, state_d;
    logic             enqueue_q, enqueue_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic [7:0]       data_q, data_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic             stall_err_q, stall_err_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req_a      (data_ready_a),
        .req_b      (data_ready_b),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        enqueue_d    = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        data_d       = data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        stall_cnt_d  = stall_cnt_q;
        stall_err_d  = stall_err_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid && queue_full) begin
                    if (stall_cnt_q != STALL_LIM) begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                    if (stall_cnt_d == STALL_LIM) begin
                        stall_err_d = 1'b1;
                    end
                end else begin
                    stall_cnt_d = 8'd0;
                    if (pick_valid) begin
                        state_d      = CAPTURE;
                        enqueue_d    = 1'b1;
                        data_d       = (pick_winner == SRC_B) ? data_b : data_a;
                        grant_d      = pick_winner;
                        last_grant_d = pick_winner;
                    end
                end
            end
            CAPTURE: begin
                state_d = ACK;
                if (grant_q == SRC_B) begin
                    ack_b_d = 1'b1;
                    cnt_b_d = cnt_b_q + CNT_W'(1);
                end else begin
                    ack_a_d = 1'b1;
                    cnt_a_d = cnt_a_q + CNT_W'(1);
                end
            end
            ACK:     state_d = HOLDOFF;
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_100KHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            enqueue_q    <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            data_q       <= 8'd0;
            grant_q      <= SRC_A;
            last_grant_q <= SRC_B;
            busy_q       <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            stall_cnt_q  <= 8'd0;
            stall_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            enqueue_q    <= enqueue_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign ack_a         = ack_a_q;
    assign ack_b         = ack_b_q;
    assign enqueue_out   = enqueue_q;
    assign data_to_queue = data_q;
    assign grant_src     = grant_q;
    assign busy          = busy_q;
    assign cnt_a         = cnt_a_q;
    assign cnt_b         = cnt_b_q;
    assign stall_err     = stall_err_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_des_ingress_arbiter.sv
// Directed bench for des_ingress_arbiter: vector table plus hand sequences.
module tb_des_ingress_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ra, rb, qf;
    logic [7:0] da, db;

    logic       ack_a, ack_b, enq, grant, busy, serr;
    logic [7:0] dq, ca, cb;
    logic [1:0] st;

    logic       w_ack_a, w_ack_b, w_enq, w_grant, w_busy, w_serr;
    logic [7:0] w_dq;
    logic [1:0] w_ca, w_cb, w_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_ingress_arbiter #(.CNT_W(8), .STALL_MAX(16)) dut (
        .clock_100KHZ(clk), .reset(rst),
        .data_ready_a(ra), .data_a(da), .ack_a(ack_a),
        .data_ready_b(rb), .data_b(db), .ack_b(ack_b),
        .queue_full(qf), .enqueue_out(enq), .data_to_queue(dq),
        .grant_src(grant), .busy(busy), .cnt_a(ca), .cnt_b(cb),
        .stall_err(serr), .state_out(st)
    );

    des_ingress_arbiter #(.CNT_W(2), .STALL_MAX(16)) dut_w (
        .clock_100KHZ(clk), .reset(rst),
        .data_ready_a(ra), .data_a(da), .ack_a(w_ack_a),
        .data_ready_b(rb), .data_b(db), .ack_b(w_ack_b),
        .queue_full(qf), .enqueue_out(w_enq), .data_to_queue(w_dq),
        .grant_src(w_grant), .busy(w_busy), .cnt_a(w_ca), .cnt_b(w_cb),
        .stall_err(w_serr), .state_out(w_st)
    );

    typedef struct {
        logic       rst, ra, rb;
        logic [7:0] da, db;
        logic       qf;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(logic r, logic a, logic b, logic [7:0] xa, logic [7:0] xb,
                                logic f, logic e_enq, logic e_aa, logic e_ab, logic [7:0] e_dq,
                                logic e_g, logic e_busy, logic [1:0] e_st, logic [7:0] e_ca,
                                logic [7:0] e_cb, logic e_se);
        vec_t v;
        v.rst = r; v.ra = a; v.rb = b; v.da = xa; v.db = xb; v.qf = f;
        v.exp = {e_enq, e_aa, e_ab, e_dq, e_g, e_busy, e_st, e_ca, e_cb, e_se};
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {enq, ack_a, ack_b, dq, grant, busy, st, ca, cb, serr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ra = 1'b0; rb = 1'b0; qf = 1'b0; da = 8'h00; db = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    // Enqueue and acks must never overlap, and the two acks are exclusive.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((enq && (ack_a || ack_b)) || (ack_a && ack_b) ||
                (w_enq && (w_ack_a || w_ack_b)) || (w_ack_a && w_ack_b)) begin
                errors++;
                $display("FAIL strobe_overlap enq=%b ack_a=%b ack_b=%b", enq, ack_a, ack_b);
            end
        end
    end

    vec_t vecs[16];
    int   ngr, last_c, enq_seen;
    logic [1:0] wexp;

    initial begin
        //          rst ra rb da     db     qf  enq aa ab dq     g  bsy st  ca     cb     se
        vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 2'd0, 8'd0, 8'd0, 0);
        vecs[1]  = mk(0, 1, 0, 8'hA5, 8'h00, 0,  1, 0, 0, 8'hA5, 0, 1, 2'd1, 8'd0, 8'd0, 0);
        vecs[2]  = mk(0, 1, 0, 8'hA5, 8'h00, 0,  0, 1, 0, 8'hA5, 0, 1, 2'd2, 8'd1, 8'd0, 0);
        vecs[3]  = mk(0, 1, 0, 8'hA5, 8'h00, 0,  0, 0, 0, 8'hA5, 0, 1, 2'd3, 8'd1, 8'd0, 0);
        vecs[4]  = mk(0, 0, 0, 8'hA5, 8'h00, 0,  0, 0, 0, 8'hA5, 0, 0, 2'd0, 8'd1, 8'd0, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'hA5, 0, 0, 2'd0, 8'd1, 8'd0, 0);
        vecs[6]  = mk(1, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 2'd0, 8'd0, 8'd0, 0);
        vecs[7]  = mk(0, 1, 1, 8'h11, 8'h22, 0,  1, 0, 0, 8'h11, 0, 1, 2'd1, 8'd0, 8'd0, 0);
        vecs[8]  = mk(0, 1, 1, 8'h11, 8'h22, 0,  0, 1, 0, 8'h11, 0, 1, 2'd2, 8'd1, 8'd0, 0);
        vecs[9]  = mk(0, 1, 1, 8'h11, 8'h22, 0,  0, 0, 0, 8'h11, 0, 1, 2'd3, 8'd1, 8'd0, 0);
        vecs[10] = mk(0, 0, 1, 8'h11, 8'h22, 0,  0, 0, 0, 8'h11, 0, 0, 2'd0, 8'd1, 8'd0, 0);
        vecs[11] = mk(0, 0, 1, 8'h11, 8'h22, 0,  1, 0, 0, 8'h22, 1, 1, 2'd1, 8'd1, 8'd0, 0);
        vecs[12] = mk(0, 0, 1, 8'h11, 8'h22, 0,  0, 0, 1, 8'h22, 1, 1, 2'd2, 8'd1, 8'd1, 0);
        vecs[13] = mk(0, 0, 1, 8'h11, 8'h22, 0,  0, 0, 0, 8'h22, 1, 1, 2'd3, 8'd1, 8'd1, 0);
        vecs[14] = mk(0, 0, 0, 8'h11, 8'h22, 0,  0, 0, 0, 8'h22, 1, 0, 2'd0, 8'd1, 8'd1, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h22, 1, 0, 2'd0, 8'd1, 8'd1, 0);

        rst = 1'b1; ra = 1'b0; rb = 1'b0; qf = 1'b0; da = 8'h00; db = 8'h00;
        #2;
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; ra = vecs[i].ra; rb = vecs[i].rb;
            da = vecs[i].da; db = vecs[i].db; qf = vecs[i].qf;
            tick();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Fairness: both sources always ready, ten grants.
        do_reset();
        ra = 1'b1; rb = 1'b1; da = 8'h10; db = 8'h20;
        ngr = 0; last_c = 0;
        for (int c = 0; c < 100 && ngr < 10; c++) begin
            tick();
            if (enq) begin
                chk($sformatf("fair_grant%0d", ngr), {31'd0, grant}, 32'(ngr % 2));
                chk($sformatf("fair_data%0d", ngr), {24'd0, dq}, (ngr % 2) ? 32'h20 : 32'h10);
                if (ngr > 0) chk("fair_spacing", 32'(c - last_c), 32'd4);
                last_c = c;
                ngr++;
            end
        end
        chk("fair_grant_count", 32'(ngr), 32'd10);
        ra = 1'b0; rb = 1'b0;
        repeat (4) tick();
        chk("fair_cnt", {16'd0, ca, cb}, {16'd0, 8'd5, 8'd5});
        chk("fair_idle", {30'd0, st}, 32'd0);

        // Back-pressure: B blocked for 20 cycles.
        do_reset();
        qf = 1'b1; rb = 1'b1; db = 8'h5C;
        enq_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (enq) enq_seen++;
            chk($sformatf("stall_err_c%0d", i), {31'd0, serr}, (i >= 16) ? 32'd1 : 32'd0);
        end
        chk("stall_no_enq", 32'(enq_seen), 32'd0);
        chk("stall_idle", {30'd0, st}, 32'd0);
        qf = 1'b0;
        tick();
        chk("stall_release", {22'd0, enq, dq, grant, serr}, {22'd0, 1'b1, 8'h5C, 1'b1, 1'b1});
        tick();
        chk("stall_ack_b", {30'd0, ack_a, ack_b}, 32'd1);
        rb = 1'b0;
        repeat (2) tick();
        chk("stall_sticky", {23'd0, serr, cb}, {23'd0, 1'b1, 8'd1});

        // Reset during CAPTURE abandons the transfer.
        do_reset();
        ra = 1'b1; da = 8'h3C;
        tick();
        chk("rst_mid_capture", {30'd0, enq, st == 2'd1}, 32'd3);
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", outs(), 32'd0);
        rst = 1'b0; rb = 1'b1; db = 8'h4D;
        tick();
        chk("rst_regrant_a", {22'd0, enq, grant, dq}, {22'd0, 1'b1, 1'b0, 8'h3C});
        tick();
        chk("rst_regrant_ack", {30'd0, ack_a, ack_b}, 32'd2);
        ra = 1'b0;
        repeat (3) tick();
        chk("rst_then_b", {22'd0, enq, grant, dq}, {22'd0, 1'b1, 1'b1, 8'h4D});
        tick();
        rb = 1'b0;
        repeat (2) tick();

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            ra = 1'b1; da = 8'(i);
            tick();
            chk($sformatf("wrap_enq%0d", i), {23'd0, w_enq, w_dq}, {23'd0, 1'b1, 8'(i)});
            tick();
            wexp = 2'(i % 4);
            chk($sformatf("wrap_cnt%0d", i), {30'd0, w_ca}, {30'd0, wexp});
            chk($sformatf("wide_cnt%0d", i), {24'd0, ca}, 32'(i));
            tick();
            ra = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_ingress_arbiter.md
Name: des_ingress_arbiter

Overview:
- Shares the single byte queue between two deserializer instances (sources A and B) in the 100 kHz domain.
- Watches each source's data_ready and picks one ready source, round-robin. It latches that source's byte, writes it to the queue with a one-cycle enqueue pulse, then returns a one-cycle ack to that source.
- It is the only writer of the queue. It also keeps per-source accepted-byte counters and a sticky stall flag for when the queue blocks too long.

Parameters:
- CNT_W, 8, width of each accepted-byte counter; counters wrap modulo 2^CNT_W.
- STALL_MAX, 16, number of consecutive blocked cycles (request pending while queue full) that sets stall_err; legal range 1..255.

Ports:
- clock_100KHZ  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on clock_100KHZ rising edge.
- data_ready_a  in  1  source A has a complete byte; held high until ack_a is seen.
- data_a  in  8  source A byte; stable while data_ready_a is high.
- ack_a  out  1  one-cycle pulse: source A byte taken.
- data_ready_b  in  1  as data_ready_a, for source B.
- data_b  in  8  as data_a, for source B.
- ack_b  out  1  as ack_a, for source B.
- queue_full  in  1  queue cannot accept a write this cycle.
- enqueue_out  out  1  one-cycle write strobe to the queue.
- data_to_queue  out  8  byte written; valid when enqueue_out=1.
- grant_src  out  1  0=A, 1=B; source of the most recent grant.
- busy  out  1  high in any state other than IDLE.
- cnt_a  out  CNT_W  bytes accepted from A.
- cnt_b  out  CNT_W  bytes accepted from B.
- stall_err  out  1  sticky; set when the blocked-cycle count reaches STALL_MAX.
- state_out  out  2  current FSM state encoding, for debug.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal last_grant=B (so A wins first), stall counter 0. Reset mid-operation abandons any transaction; no ack or enqueue is issued for it.
- All outputs are registered.
- FSM states: IDLE=0, CAPTURE=1, ACK=2, HOLDOFF=3.
- IDLE, pending request and queue_full=1: stay in IDLE, increment the stall counter (saturating at STALL_MAX). Set stall_err when the count equals STALL_MAX.
- IDLE, no request pending, or queue_full=0: clear the stall counter.
- IDLE, queue_full=0 and at least one data_ready high: choose the winner and go to CAPTURE.
  - Only one source ready: that source wins.
  - Both ready: the source that is not last_grant wins.
  - On the transition edge: latch the winner's byte into data_to_queue; set grant_src=winner and last_grant=winner; drive enqueue_out=1.
- CAPTURE: lasts one cycle with enqueue_out=1. Next edge: enqueue_out=0, winner's ack=1, increment that source's counter; go to ACK.
- ACK: lasts one cycle with the ack high. Next edge: ack=0; go to HOLDOFF.
- HOLDOFF: one cycle in which data_ready inputs are ignored, because a source samples ack at the end of the ACK cycle and only drops data_ready one cycle later. Next edge: go to IDLE.
- Latency: request seen at edge k gives enqueue_out high in cycle k+1, ack high in cycle k+2, and the earliest next grant at edge k+4.
- queue_full is sampled only in IDLE. A grant in progress always completes, which is safe because this block is the only writer.
- enqueue_out and the acks are never high in the same cycle. ack_a and ack_b are never high together.
- data_to_queue holds its last value outside CAPTURE.
- Counters wrap: 2^CNT_W-1 +1 -> 0.
- stall_err clears only on reset.
- A data_ready that drops before its grant is not an error; it is simply not granted.

Decomposition:
- Package des_arb_pkg holds the arb_state_t enum (IDLE, CAPTURE, ACK, HOLDOFF; 2-bit logic) and the constants SRC_A=1'b0, SRC_B=1'b1.
- Sub-module rr_pick2: combinational round-robin choice.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: valid, winner.
  - Instantiated once; everything else stays in des_ingress_arbiter.

Test Plan:
- Single source: reset, then data_ready_a=1 with data_a=8'hA5 and queue_full=0 -> enqueue_out=1 with data_to_queue=A5 one cycle after the request is seen, ack_a pulse the next cycle, cnt_a=1, ack_b never high, grant_src=0.
- Simultaneous requests: both ready, A=8'h11, B=8'h22, each held until acked -> queue receives 11 then 22, grants start 4 cycles apart, cnt_a=1, cnt_b=1, then an idle return.
- Fairness: A and B continuously re-requesting for 10 grants -> grant_src sequence 0,1,0,1,... and cnt_a=cnt_b=5.
- Back-pressure: queue_full=1 with data_ready_b=1 for 20 cycles (STALL_MAX=16) -> no enqueue, stall_err set after the 16th blocked cycle; release queue_full -> byte enqueued, stall_err stays 1.
- Reset mid-operation: assert reset in the CAPTURE cycle -> next cycle all outputs 0, no ack issued; the source still ready is re-granted with A priority.
- Wrap: CNT_W=2, five A transfers -> cnt_a reads 1,2,3,0,1.
